io_terminal: RTL and testbench
==============================

IO_TERMINAL -- requirements
Module: io_terminal

Interface
REQ-001 The module SHALL have parameter PRINT_DELAY, default 4: the number of busy cycles after each printer handshake before FGO is set again (range 1..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port CLR_GLOBAL, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port kb_data, input, 8 bits: character from the keyboard source.
REQ-005 The module SHALL have port kb_valid, input, 1 bit: kb_data is valid.
REQ-006 The module SHALL have port kb_ready, output, 1 bit: the terminal can accept a keyboard character.
REQ-007 The module SHALL have port outt_INPR, output, 8 bits: character presented to the CPU input register.
REQ-008 The module SHALL have port FGI, output, 1 bit: input flag; outt_INPR holds an unread character.
REQ-009 The module SHALL have port inp_ack, input, 1 bit: one-cycle pulse, the CPU executed INP.
REQ-010 The module SHALL have port outr_data, input, 8 bits: CPU OUTR contents.
REQ-011 The module SHALL have port out_strobe, input, 1 bit: one-cycle pulse, the CPU executed OUT.
REQ-012 The module SHALL have port FGO, output, 1 bit: output flag; the terminal can take a new character.
REQ-013 The module SHALL have ports prn_data (output, 8 bits), prn_valid (output, 1 bit) and prn_ready (input, 1 bit): the printer sink handshake.
REQ-014 The module SHALL have ports ien (input, 1 bit: CPU interrupt enable), irq (output, 1 bit) and out_ovr (output, 1 bit: sticky overrun flag).

Function
REQ-015 The input channel SHALL be an FSM with states I_EMPTY and I_FULL; kb_ready = (state == I_EMPTY); FGI = (state == I_FULL).
REQ-016 In I_EMPTY, kb_valid SHALL load kb_data into outt_INPR and enter I_FULL at that edge, so FGI = 1 on the next cycle.
REQ-017 In I_FULL, inp_ack SHALL enter I_EMPTY; outt_INPR SHALL hold its value; kb_valid SHALL be ignored in that same cycle.
REQ-018 inp_ack in I_EMPTY SHALL have no effect.
REQ-019 The output channel SHALL be an FSM with states O_IDLE, O_SEND and O_WAIT; FGO = (state == O_IDLE).
REQ-020 In O_IDLE, out_strobe SHALL capture outr_data into prn_data and enter O_SEND.
REQ-021 In O_SEND, prn_valid SHALL be 1 and prn_data SHALL be held stable until prn_ready is sampled high, then the FSM SHALL enter O_WAIT and load the counter with PRINT_DELAY-1.
REQ-022 In O_WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL enter O_IDLE, so FGO rises exactly PRINT_DELAY cycles after the accepting prn_ready edge.
REQ-023 out_strobe outside O_IDLE SHALL be dropped, SHALL set out_ovr, and SHALL leave prn_data unchanged; out_ovr SHALL clear only on reset.
REQ-024 Both channels SHALL operate independently and concurrently, with no shared state.

Reset
REQ-025 CLR_GLOBAL SHALL immediately force I_EMPTY, O_IDLE, outt_INPR = 0, prn_data = 0, counter = 0, out_ovr = 0 and irq = 0, so that FGI = 0, FGO = 1, kb_ready = 1 and prn_valid = 0.
REQ-026 Reset asserted mid-transfer SHALL abandon the transfer; the first edge after release SHALL behave as from idle.

Configuration
REQ-027 With macro IO_TERMINAL_IRQ_EN defined, irq SHALL be a register updated each cycle to ien & (FGI | FGO), giving one cycle of latency.
REQ-028 Without IO_TERMINAL_IRQ_EN, irq SHALL be tied to 0 and ien SHALL be unused.

Structure
REQ-029 The package io_terminal_pkg SHALL hold the input and output state enums and the PRINT_DELAY default constant.
REQ-030 The output channel (FSM, counter and overrun flag) SHALL be the sub-module io_out_channel; the input channel SHALL remain inline.

Verification
REQ-031 Reset check: after reset -> FGI=0, FGO=1, kb_ready=1, prn_valid=0, outt_INPR=00.
REQ-032 Keyboard load and INP: kb_data=FF with kb_valid for 1 cycle -> next cycle FGI=1, outt_INPR=FF, kb_ready=0; inp_ack pulse -> FGI=0, outt_INPR=FF.
REQ-033 Keyboard blocked while full: kb_valid held with data 41 then 42 while FGI=1 -> outt_INPR stays 41 until inp_ack; 42 is accepted the cycle after FGI falls.
REQ-034 Print path: outr_data=5A with out_strobe, prn_ready high after 3 cycles, PRINT_DELAY=4 -> FGO=0, prn_valid=1 with prn_data=5A for 3 cycles, FGO=1 four cycles after acceptance.
REQ-035 Overrun: second out_strobe with outr_data=77 while FGO=0 -> out_ovr=1, printer emits only the first byte.
REQ-036 IRQ and reset: with IO_TERMINAL_IRQ_EN and ien=1, FGI rise -> irq=1 one cycle later; CLR_GLOBAL during O_SEND -> FGO=1 and prn_valid=0 immediately.

Source files
------------

// File: rtl/io_terminal_pkg.sv
// -----------------------------------------------------------------------------
// io_terminal_pkg
// Shared types and constants for the io_terminal block:
//   in_state_e  - keyboard/input channel states (I_EMPTY, I_FULL)
//   out_state_e - printer/output channel states (O_IDLE, O_SEND, O_WAIT)
//   PRINT_DELAY_DEFAULT - default number of busy cycles after a printer handshake
//   CNT_W       - width of the print-delay counter (covers PRINT_DELAY 1..255)
// -----------------------------------------------------------------------------
package io_terminal_pkg;

  localparam int PRINT_DELAY_DEFAULT = 4;
  localparam int CNT_W               = 8;

  typedef enum logic {
    I_EMPTY = 1'b0,
    I_FULL  = 1'b1
  } in_state_e;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_SEND = 2'd1,
    O_WAIT = 2'd2
  } out_state_e;

endpackage : io_terminal_pkg

// File: rtl/io_out_channel.sv
// -----------------------------------------------------------------------------
// io_out_channel
// Output (printer) channel of the terminal: captures the CPU OUTR byte on
// out_strobe, presents it to the printer with a valid/ready handshake, then
// stays busy for PRINT_DELAY cycles before raising FGO again.
//
// Parameters:
//   PRINT_DELAY  - busy cycles after the accepting prn_ready edge (1..255)
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   out_strobe_i - one-cycle pulse, CPU executed OUT
//   outr_data_i  - CPU OUTR contents
//   prn_ready_i  - printer accepts prn_data this cycle
//   prn_data_o   - byte presented to the printer
//   prn_valid_o  - prn_data_o is valid
//   fgo_o        - output flag, channel can take a new character
//   out_ovr_o    - sticky overrun flag (strobe while busy), cleared by reset
// -----------------------------------------------------------------------------
module io_out_channel
  import io_terminal_pkg::*;
#(
  parameter int PRINT_DELAY = PRINT_DELAY_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out_strobe_i,
  input  logic [7:0] outr_data_i,
  input  logic       prn_ready_i,
  output logic [7:0] prn_data_o,
  output logic       prn_valid_o,
  output logic       fgo_o,
  output logic       out_ovr_o
);

  out_state_e       state_q, state_d;
  logic [7:0]       data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             ovr_q,   ovr_d;

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves it unassigned (that would infer a latch).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      O_IDLE: begin
        if (out_strobe_i) begin
          data_d  = outr_data_i;
          state_d = O_SEND;
        end
      end
      O_SEND: begin
        if (prn_ready_i) begin
          state_d = O_WAIT;
          cnt_d   = CNT_W'(PRINT_DELAY - 1);
        end
      end
      O_WAIT: begin
        // Counter runs PRINT_DELAY-1 .. 0, so the return to O_IDLE lands
        // exactly PRINT_DELAY edges after the accepting handshake edge.
        if (cnt_q == '0) begin
          state_d = O_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = O_IDLE;
    endcase

    // A strobe while busy is dropped; prn_data is untouched above.
    if (out_strobe_i && (state_q != O_IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  // The data register is reset too: prn_data must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= O_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign prn_data_o  = data_q;
  assign prn_valid_o = (state_q == O_SEND);
  assign fgo_o       = (state_q == O_IDLE);
  assign out_ovr_o   = ovr_q;

endmodule : io_out_channel

// File: rtl/io_terminal.sv
// -----------------------------------------------------------------------------
// io_terminal
// Character terminal between a keyboard source, a printer sink and a simple
// CPU (INPR/OUTR registers with FGI/FGO flags). The input channel is inline;
// the output channel lives in io_out_channel. The two share no state.
//
// Configuration macro:
//   IO_TERMINAL_IRQ_EN - when defined, irq is a register of ien & (FGI | FGO)
//                        (one cycle latency); otherwise irq = 0, ien unused.
// Parameters:
//   PRINT_DELAY - busy cycles after each printer handshake (1..255)
// Ports:
//   clk, CLR_GLOBAL         - clock (rising edge), async active-high reset
//   kb_data, kb_valid       - keyboard character and its valid
//   kb_ready                - terminal can accept a keyboard character
//   outt_INPR, FGI          - character for the CPU and its "unread" flag
//   inp_ack                 - one-cycle pulse, CPU executed INP
//   outr_data, out_strobe   - CPU OUTR contents and OUT pulse
//   FGO                     - output channel can take a new character
//   prn_data/valid/ready    - printer handshake
//   ien, irq                - interrupt enable and request
//   out_ovr                 - sticky output overrun flag
// -----------------------------------------------------------------------------
module io_terminal
  import io_terminal_pkg::*;
#(
  parameter int PRINT_DELAY = PRINT_DELAY_DEFAULT
) (
  input  logic       clk,
  input  logic       CLR_GLOBAL,
  input  logic [7:0] kb_data,
  input  logic       kb_valid,
  output logic       kb_ready,
  output logic [7:0] outt_INPR,
  output logic       FGI,
  input  logic       inp_ack,
  input  logic [7:0] outr_data,
  input  logic       out_strobe,
  output logic       FGO,
  output logic [7:0] prn_data,
  output logic       prn_valid,
  input  logic       prn_ready,
  input  logic       ien,
  output logic       irq,
  output logic       out_ovr
);

  // ---------------- input channel ----------------
  in_state_e  in_state_q, in_state_d;
  logic [7:0] inpr_q,     inpr_d;

  always_comb begin
    in_state_d = in_state_q;
    inpr_d     = inpr_q;
    unique case (in_state_q)
      I_EMPTY: begin
        if (kb_valid) begin
          inpr_d     = kb_data;
          in_state_d = I_FULL;
        end
      end
      // kb_valid is ignored while full, including the inp_ack cycle.
      I_FULL: begin
        if (inp_ack) begin
          in_state_d = I_EMPTY;
        end
      end
      default: in_state_d = I_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge CLR_GLOBAL) begin
    if (CLR_GLOBAL) begin
      in_state_q <= I_EMPTY;
      inpr_q     <= '0;
    end else begin
      in_state_q <= in_state_d;
      inpr_q     <= inpr_d;
    end
  end

  assign kb_ready  = (in_state_q == I_EMPTY);
  assign FGI       = (in_state_q == I_FULL);
  assign outt_INPR = inpr_q;

  // ---------------- output channel ----------------
  io_out_channel #(
    .PRINT_DELAY (PRINT_DELAY)
  ) u_out (
    .clk          (clk),
    .rst          (CLR_GLOBAL),
    .out_strobe_i (out_strobe),
    .outr_data_i  (outr_data),
    .prn_ready_i  (prn_ready),
    .prn_data_o   (prn_data),
    .prn_valid_o  (prn_valid),
    .fgo_o        (FGO),
    .out_ovr_o    (out_ovr)
  );

  // ---------------- interrupt ----------------
`ifdef IO_TERMINAL_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge CLR_GLOBAL) begin
    if (CLR_GLOBAL) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ien & (FGI | FGO);
    end
  end

  assign irq = irq_q;
`else
  logic ien_unused;
  assign ien_unused = ien;
  assign irq        = 1'b0;
`endif

endmodule : io_terminal

// File: tb/tb_io_terminal.sv
// -----------------------------------------------------------------------------
// tb_io_terminal
// Self-checking bench for io_terminal (PRINT_DELAY = 4). Input-channel
// behaviour is driven from a vector table; the print path, overrun, interrupt
// and mid-transfer reset are hand-written sequences. Honours
// IO_TERMINAL_IRQ_EN for the expected irq value.
// -----------------------------------------------------------------------------
module tb_io_terminal;

`ifdef IO_TERMINAL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       CLR_GLOBAL;
  logic [7:0] kb_data;
  logic       kb_valid;
  logic       kb_ready;
  logic [7:0] outt_INPR;
  logic       FGI;
  logic       inp_ack;
  logic [7:0] outr_data;
  logic       out_strobe;
  logic       FGO;
  logic [7:0] prn_data;
  logic       prn_valid;
  logic       prn_ready;
  logic       ien;
  logic       irq;
  logic       out_ovr;

  int n_checks = 0;
  int n_fail   = 0;

  // Printer-side record of accepted bytes.
  int         n_prn    = 0;
  logic [7:0] last_prn = 8'h00;

  always #5 clk = ~clk;

  io_terminal #(
    .PRINT_DELAY (4)
  ) dut (
    .clk        (clk),
    .CLR_GLOBAL (CLR_GLOBAL),
    .kb_data    (kb_data),
    .kb_valid   (kb_valid),
    .kb_ready   (kb_ready),
    .outt_INPR  (outt_INPR),
    .FGI        (FGI),
    .inp_ack    (inp_ack),
    .outr_data  (outr_data),
    .out_strobe (out_strobe),
    .FGO        (FGO),
    .prn_data   (prn_data),
    .prn_valid  (prn_valid),
    .prn_ready  (prn_ready),
    .ien        (ien),
    .irq        (irq),
    .out_ovr    (out_ovr)
  );

  always @(posedge clk) begin
    if (prn_valid && prn_ready) begin
      n_prn    <= n_prn + 1;
      last_prn <= prn_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] kb;
    logic       valid;
    logic       ack;
    logic       exp_fgi;
    logic [7:0] exp_inpr;
    logic       exp_kbr;
  } in_vec_t;

  in_vec_t vecs[12];

  initial begin
    // kb     valid ack | fgi inpr  kb_ready
    vecs[0]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0}; // load FF
    vecs[1]  = '{8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0}; // hold
    vecs[2]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1}; // INP, data held
    vecs[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1}; // INP while empty: no effect
    vecs[4]  = '{8'h41, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0}; // load 41
    vecs[5]  = '{8'h42, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0}; // blocked while full
    vecs[6]  = '{8'h42, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0}; // still blocked
    vecs[7]  = '{8'h42, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1}; // INP, kb_valid ignored
    vecs[8]  = '{8'h42, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0}; // 42 accepted after FGI fell
    vecs[9]  = '{8'h43, 1'b0, 1'b1, 1'b0, 8'h42, 1'b1}; // INP
    vecs[10] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0}; // zero byte
    vecs[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1}; // INP

    CLR_GLOBAL = 1'b1;
    kb_data    = 8'h00;
    kb_valid   = 1'b0;
    inp_ack    = 1'b0;
    outr_data  = 8'h00;
    out_strobe = 1'b0;
    prn_ready  = 1'b0;
    ien        = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    check("rst_fgi",       FGI,       0);
    check("rst_fgo",       FGO,       1);
    check("rst_kb_ready",  kb_ready,  1);
    check("rst_prn_valid", prn_valid, 0);
    check("rst_inpr",      outt_INPR, 8'h00);
    check("rst_prn_data",  prn_data,  8'h00);
    check("rst_ovr",       out_ovr,   0);
    check("rst_irq",       irq,       0);
    @(negedge clk);
    CLR_GLOBAL = 1'b0;
    tick();
    check("idle_fgo", FGO, 1);
    check("idle_fgi", FGI, 0);

    // ---- input channel vectors ----
    for (int i = 0; i < 12; i++) begin
      kb_data  = vecs[i].kb;
      kb_valid = vecs[i].valid;
      inp_ack  = vecs[i].ack;
      tick();
      check($sformatf("vec%0d_fgi", i),      FGI,       vecs[i].exp_fgi);
      check($sformatf("vec%0d_inpr", i),     outt_INPR, vecs[i].exp_inpr);
      check($sformatf("vec%0d_kb_ready", i), kb_ready,  vecs[i].exp_kbr);
    end
    kb_valid = 1'b0;
    inp_ack  = 1'b0;

    // ---- print path with overrun ----
    outr_data  = 8'h5A;
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    check("prn_a_fgo",   FGO,       0);
    check("prn_a_valid", prn_valid, 1);
    check("prn_a_data",  prn_data,  8'h5A);
    check("prn_a_ovr",   out_ovr,   0);
    // Second strobe while busy must be dropped.
    outr_data  = 8'h77;
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    check("prn_b_valid", prn_valid, 1);
    check("prn_b_data",  prn_data,  8'h5A);
    check("prn_b_ovr",   out_ovr,   1);
    tick();
    check("prn_c_valid", prn_valid, 1);
    check("prn_c_data",  prn_data,  8'h5A);
    prn_ready = 1'b1;
    tick(); // accepting edge
    prn_ready = 1'b0;
    check("prn_acc_valid", prn_valid, 0);
    check("prn_acc_fgo",   FGO,       0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("prn_wait%0d_fgo", k), FGO, (k == 4) ? 1 : 0);
    end
    check("prn_count", n_prn,    1);
    check("prn_byte",  last_prn, 8'h5A);
    check("ovr_sticky", out_ovr, 1);

    // ---- interrupt and mid-transfer reset ----
    outr_data  = 8'h99;
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    ien        = 1'b1;
    check("irq_send_valid", prn_valid, 1);
    tick();
    check("irq_busy_low", irq, 0);
    kb_data  = 8'h3C;
    kb_valid = 1'b1;
    tick();
    kb_valid = 1'b0;
    check("irq_fgi_rise", FGI, 1);
    check("irq_lag",      irq, 0);
    tick();
    check("irq_set", irq, IRQ_EN ? 1 : 0);
    check("irq_still_send", prn_valid, 1);
    #2;
    CLR_GLOBAL = 1'b1;
    #1;
    check("clr_fgo",       FGO,       1);
    check("clr_prn_valid", prn_valid, 0);
    check("clr_fgi",       FGI,       0);
    check("clr_inpr",      outt_INPR, 8'h00);
    check("clr_prn_data",  prn_data,  8'h00);
    check("clr_ovr",       out_ovr,   0);
    check("clr_irq",       irq,       0);
    ien = 1'b0;
    @(negedge clk);
    CLR_GLOBAL = 1'b0;
    // First edge after release behaves as from idle.
    outr_data  = 8'h11;
    out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    check("post_valid", prn_valid, 1);
    check("post_data",  prn_data,  8'h11);
    check("post_ovr",   out_ovr,   0);
    prn_ready = 1'b1;
    tick();
    prn_ready = 1'b0;
    repeat (4) tick();
    check("post_fgo",   FGO,      1);
    check("post_count", n_prn,    2);
    check("post_byte",  last_prn, 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_io_terminal
